// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming KSIZE x KSIZE convolution with line buffers and a serial MAC
module conv_stream_engine #(
  parameter int WIDTH     = 15,
  parameter int HEIGHT    = 19,
  parameter int DATA_BITS = 32,
  parameter int KSIZE     = 3,
  parameter int SHIFT     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_BITS-1:0]             in_data,
  input  logic [KSIZE*KSIZE*DATA_BITS-1:0] weights,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BITS-1:0]             out_data,
  output logic                             out_last
);
  localparam int NTAP  = KSIZE * KSIZE;
  localparam int ACC_W = 2 * DATA_BITS + $clog2(NTAP);
  localparam int TW    = $clog2(NTAP + 1);
  localparam int TN    = 1 << TW;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KSIZE - 1);
  localparam logic [TW-1:0] TAP_END  = TW'(NTAP);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {FILL, MAC, OUT} state_t;
  state_t state, state_nx;

  logic [RW-1:0]             row;
  logic [CW-1:0]             col;
  logic [TW-1:0]             tap;
  logic signed [ACC_W-1:0]   acc;
  logic                      last_pend;
  logic [DATA_BITS-1:0]      line_buf [KSIZE-1][WIDTH];
  logic [DATA_BITS-1:0]      win      [KSIZE][KSIZE];
  logic [DATA_BITS-1:0]      win_nx   [KSIZE][KSIZE];
  logic [DATA_BITS-1:0]      col_nx   [KSIZE];
  logic [TN*DATA_BITS-1:0]   ops;
  logic [TN*DATA_BITS-1:0]   ops_nx;
  logic [TN*DATA_BITS-1:0]   wt_flat;
  logic signed [DATA_BITS-1:0]   op_a, op_b;
  logic signed [2*DATA_BITS-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, acc_sh;
  logic [DATA_BITS-1:0]      sat;
  logic                      accept, win_done, frame_end;

  assign in_ready  = rst_n && (state == FILL);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign win_done  = accept && (row >= ROW_WIN) && (col >= COL_WIN);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // Padding the tap vectors to a power of two keeps the tap-indexed selects in range.
  assign wt_flat  = {{((TN-NTAP)*DATA_BITS){1'b0}}, weights};
  assign op_a     = ops[tap*DATA_BITS +: DATA_BITS];
  assign op_b     = wt_flat[tap*DATA_BITS +: DATA_BITS];
  assign prod     = (2*DATA_BITS)'(op_a) * (2*DATA_BITS)'(op_b);
  assign prod_ext = ACC_W'(prod);
  assign acc_sh   = acc >>> SHIFT;
  assign sat      = (acc_sh > SAT_MAX) ? SAT_MAX[DATA_BITS-1:0] :
                    (acc_sh < SAT_MIN) ? SAT_MIN[DATA_BITS-1:0] : acc_sh[DATA_BITS-1:0];

  // Row 0 of the window is the oldest line; the incoming pixel lands bottom-right.
  always_comb begin
    ops_nx = '0;
    for (int r = 0; r < KSIZE - 1; r++) col_nx[r] = line_buf[KSIZE-2-r][col];
    col_nx[KSIZE-1] = in_data;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) win_nx[r][c] = win[r][c+1];
      win_nx[r][KSIZE-1] = col_nx[r];
    end
    for (int i = 0; i < NTAP; i++) ops_nx[i*DATA_BITS +: DATA_BITS] = win_nx[i/KSIZE][i%KSIZE];
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (win_done) state_nx = MAC;
      MAC:     if (tap == TAP_END) state_nx = OUT;
      OUT:     if (out_ready) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= in_data;
      for (int i = 1; i < KSIZE - 1; i++) line_buf[i][col] <= line_buf[i-1][col];
      win <= win_nx;
    end
    if (win_done) ops <= ops_nx;
  end

  // The MAC spends one extra cycle at tap==NTAP to register the saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      acc       <= '0;
      last_pend <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (win_done) begin
        acc       <= '0;
        tap       <= '0;
        last_pend <= frame_end;
      end else if (state == MAC) begin
        if (tap == TAP_END) begin
          out_data <= sat;
          out_last <= last_pend;
        end else begin
          acc <= acc + prod_ext;
          tap <= tap + 1'b1;
        end
      end else if (state == OUT && out_ready) begin
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - randomized scoreboard bench for conv_stream_engine
module tb_conv_stream_engine;
  localparam int W = 5, H = 5, K = 3, DB = 32, NT = K * K;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last;
  logic [DB-1:0] in_data = '0, out_data;
  logic [NT*DB-1:0] weights = '0;

  logic in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [7:0] in_data_a = '0, in_data_b = '0, out_data_a, out_data_b;
  logic [NT*8-1:0] weights_a = '0, weights_b = '0;

  always #5 clk = ~clk;

  conv_stream_engine #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .KSIZE(K), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weights(weights), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last));

  conv_stream_engine #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(8), .KSIZE(K), .SHIFT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready_a), .in_data(in_data_a),
    .weights(weights_a), .out_valid(out_valid_a), .out_ready(out_ready8), .out_data(out_data_a),
    .out_last(out_last_a));

  conv_stream_engine #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(8), .KSIZE(K), .SHIFT(7)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready_b), .in_data(in_data_b),
    .weights(weights_b), .out_valid(out_valid_b), .out_ready(out_ready8), .out_data(out_data_b),
    .out_last(out_last_b));

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic signed [DB-1:0] pix [H][W];
  logic signed [DB-1:0] wt [NT];
  logic [DB-1:0] exp_data [$];
  bit exp_last [$];
  int frames_full = 0, last_cnt = 0;
  int bp_mode = 0, hold_cnt = 0;

  // Reference: direct sum over each valid window position, raster order of window origin.
  task automatic model_frame();
    logic signed [79:0] acc;
    for (int wr = 0; wr <= H - K; wr++)
      for (int wc = 0; wc <= W - K; wc++) begin
        acc = '0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) acc += pix[wr+r][wc+c] * wt[r*K+c];
        if (acc > 80'sd2147483647) exp_data.push_back(32'h7fffffff);
        else if (acc < -80'sd2147483648) exp_data.push_back(32'h80000000);
        else exp_data.push_back(acc[31:0]);
        exp_last.push_back(wr == H - K && wc == W - K);
      end
  endtask

  task automatic set_weights();
    for (int i = 0; i < NT; i++) weights[i*DB +: DB] = wt[i];
  endtask

  task automatic rand_weights(input bit full);
    for (int i = 0; i < NT; i++) wt[i] = full ? $urandom : $urandom_range(200) - 100;
    set_weights();
  endtask

  task automatic gen_frame(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       pix[r][c] = 1;
          1:       pix[r][c] = r * W + c;
          2:       pix[r][c] = $urandom_range(200) - 100;
          default: pix[r][c] = $urandom;
        endcase
  endtask

  task automatic drive_frame(input int gap, input int npix);
    if (npix == W * H) begin
      model_frame();
      frames_full++;
    end
    for (int p = 0; p < npix; p++) begin
      bit done = 0;
      int n = 0;
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pix[p/W][p%W];
      while (!done && n < 500) begin
        @(negedge clk);
        done = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!done) check_eq("in_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    exp_data.delete();
    exp_last.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain", exp_data.size(), 0);
    check_eq("last_count", last_cnt, frames_full);
  endtask

  task automatic run8(input string tag_a, input logic [7:0] exp_a, input string tag_b, input logic [7:0] exp_b);
    bit got_a = 0, got_b = 0;
    do_reset();
    in_valid8 = 1'b1;
    for (int n = 0; n < 300 && !(got_a && got_b); n++) begin
      @(negedge clk);
      if (out_valid_a && !got_a) begin check_eq(tag_a, out_data_a, exp_a); got_a = 1; end
      if (out_valid_b && !got_b) begin check_eq(tag_b, out_data_b, exp_b); got_b = 1; end
    end
    check_eq({tag_a, "_seen"}, got_a, 1);
    check_eq({tag_b, "_seen"}, got_b, 1);
    in_valid8 = 1'b0;
  endtask

  // Downstream backpressure: 0 always ready, 1 random, 2 stall each result for 5 cycles.
  initial forever begin
    @(posedge clk); #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(3) != 0);
      default: begin
        hold_cnt  = out_valid ? hold_cnt + 1 : 0;
        out_ready = (hold_cnt > 5);
      end
    endcase
  end

  int cyc = 0, t_in = 0, stall_cnt = 0;
  bit prev_valid = 0, prev_stall = 0, prev_last = 0;
  logic [DB-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_stall = 0;
      stall_cnt  = 0;
    end else begin
      if (out_valid) check_eq("in_ready_in_out", in_ready, 0);
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      if (out_valid && !prev_valid) check_eq("latency", cyc - t_in, NT + 1);
      if (in_valid && in_ready) t_in = cyc + 1;
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          check_eq("out_data", out_data, exp_data.pop_front());
          check_eq("out_last", out_last, exp_last.pop_front());
        end
        if (bp_mode == 2) check_eq("stall_cycles", stall_cnt, 5);
        if (out_last) last_cnt++;
        stall_cnt = 0;
      end else if (out_valid) begin
        stall_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();

    for (int i = 0; i < NT; i++) wt[i] = 1;
    set_weights();
    gen_frame(0);
    drive_frame(0, W * H);
    drain();

    for (int i = 0; i < NT; i++) wt[i] = (i == 4) ? 1 : 0;
    set_weights();
    gen_frame(1);
    drive_frame(0, W * H);
    drain();

    for (int i = 0; i < NT; i++) wt[i] = 1;
    set_weights();
    bp_mode = 2;
    gen_frame(0);
    drive_frame(0, W * H);
    drain();
    bp_mode = 0;

    gen_frame(0);
    drive_frame(0, 13);
    do_reset();
    drive_frame(0, W * H);
    drain();

    bp_mode = 1;
    rand_weights(0);
    gen_frame(2);
    drive_frame(30, W * H);
    drive_frame(30, W * H);
    drain();

    for (int f = 0; f < 6; f++) begin
      rand_weights(f % 2 == 1);
      gen_frame((f % 2 == 1) ? 3 : 2);
      drive_frame(20, W * H);
      drain();
    end
    bp_mode = 0;

    weights_a = {9{8'd127}};
    weights_b = {9{8'd64}};
    in_data_a = 8'd127;
    in_data_b = 8'd1;
    run8("sat_pos", 8'h7f, "shift7", 8'h04);
    in_data_a = 8'h80;
    run8("sat_neg", 8'h80, "shift7_again", 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_stream_engine.md
CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 Parameter WIDTH, default 15, meaning input frame width in pixels (>= KSIZE).
REQ-002 Parameter HEIGHT, default 19, meaning input frame height in pixels (>= KSIZE).
REQ-003 Parameter DATA_BITS, default 32, meaning signed two's-complement pixel, weight and result width.
REQ-004 Parameter KSIZE, default 3, meaning square kernel edge (2..7).
REQ-005 Parameter SHIFT, default 0, meaning arithmetic right shift applied to the accumulator before saturation.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  in_data holds a valid pixel.
REQ-009 in_ready  output  1  block accepts a pixel this cycle.
REQ-010 in_data  input  DATA_BITS  pixel, raster order (row-major, column 0 first).
REQ-011 weights  input  KSIZE*KSIZE*DATA_BITS  kernel taps, tap (r,c) at slice index r*KSIZE+c, LSB slice = tap (0,0); held static during a frame.
REQ-012 out_valid  output  1  out_data holds a result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  DATA_BITS  saturated convolution result.
REQ-015 out_last  output  1  qualifies the final result of a frame.

Function
REQ-016 Pixel transfer occurs on a rising edge where in_valid=1 and in_ready=1; result transfer where out_valid=1 and out_ready=1.
REQ-017 Block holds KSIZE-1 line buffers of WIDTH entries plus a KSIZE x KSIZE window register; no derived or divided clocks are used.
REQ-018 Column counter wraps WIDTH-1 -> 0 and increments row counter; row counter wraps HEIGHT-1 -> 0, starting a new frame with no reset required.
REQ-019 A window is complete when the accepted pixel has row >= KSIZE-1 and column >= KSIZE-1; it yields (WIDTH-KSIZE+1)*(HEIGHT-KSIZE+1) results per frame; windows never span a row boundary.
REQ-020 FSM states: FILL, MAC, OUT.
REQ-021 FILL: in_ready=1; on a transfer completing a window, snapshot window into a MAC operand register and go to MAC; otherwise stay in FILL.
REQ-022 MAC: in_ready=0; one signed multiply-accumulate per cycle over KSIZE*KSIZE taps, tap index 0 first; after the last tap go to OUT.
REQ-023 OUT: out_valid=1, in_ready=0; out_data and out_last stay stable until transfer; on transfer go to FILL.
REQ-024 Latency: out_valid rises exactly KSIZE*KSIZE+1 cycles after the window-completing input transfer edge.
REQ-025 Accumulator is 2*DATA_BITS+$clog2(KSIZE*KSIZE) bits signed, cleared at MAC entry; no intermediate overflow.
REQ-026 Result = accumulator >>> SHIFT, saturated to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
REQ-027 out_last=1 only on the result from window at row HEIGHT-1, column WIDTH-1.
REQ-028 in_valid=0 in FILL holds all counters and buffers unchanged.
REQ-029 Changing weights during MAC or OUT is undefined behaviour; the bench does not do this.

Reset
REQ-030 rst_n low asynchronously forces state=FILL, row/column counters=0, accumulator=0, tap index=0, out_valid=0, out_last=0, out_data=0, in_ready=0 while rst_n low.
REQ-031 Line-buffer contents are not reset; they are never read before being written within a frame.
REQ-032 Reset asserted mid-frame or mid-MAC discards the partial frame; first pixel after release is frame pixel (0,0); in_ready=1 on the first cycle after release.

Verification
REQ-033 WIDTH=5, HEIGHT=5, KSIZE=3, all pixels 1, all weights 1, out_ready=1 -> 9 results of value 9, out_last only on the 9th, each out_valid 10 cycles after its completing pixel.
REQ-034 Same config, pixel value = row*5+col, weights one-hot at tap 4 -> results 6,7,8,11,12,13,16,17,18 in order.
REQ-035 Hold out_ready=0 for 5 cycles during OUT -> out_valid=1, out_data unchanged, in_ready=0 throughout; transfer on first out_ready=1 cycle.
REQ-036 DATA_BITS=8, pixels 127, weights 127, SHIFT=0 -> out_data=127; pixels -128, weights 127 -> out_data=-128; SHIFT=7 with pixels 1, weights 64 -> out_data=4.
REQ-037 Assert rst_n=0 for 2 cycles after 13 pixels of a frame, then stream a full frame -> outputs identical to REQ-033, no stale results.
REQ-038 Stream two back-to-back frames with random in_valid gaps -> second frame results identical to first, out_last once per frame.
